// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin share of one single-port SPI RAM by two
// requesters; each transaction is an address step then a data/read step.
module spi_ram_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 4
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic                 req0_we,
   input  logic [ADDR_SIZE-1:0] req0_addr,
   input  logic [7:0]           req0_wdata,
   output logic                 rsp0_valid,
   output logic [7:0]           rsp0_rdata,
   output logic                 rsp0_err,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic                 req1_we,
   input  logic [ADDR_SIZE-1:0] req1_addr,
   input  logic [7:0]           req1_wdata,
   output logic                 rsp1_valid,
   output logic [7:0]           rsp1_rdata,
   output logic                 rsp1_err,
   output logic [9:0]           ram_din,
   output logic                 ram_rx_valid,
   input  logic [7:0]           ram_dout,
   input  logic                 ram_tx_valid
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      WAIT_RD
   } state_t;

   state_t               state_q, state_d;
   logic                 id_q, id_d;
   logic                 we_q, we_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 last_q, last_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [9:0]           din_q, din_d;
   logic                 rxv_q, rxv_d;
   logic [1:0]           rspv_q, rspv_d;
   logic [1:0]           err_q, err_d;
   logic [7:0]           rdata0_q, rdata0_d;
   logic [7:0]           rdata1_q, rdata1_d;

   logic                 grant0;
   logic                 grant1;
   logic                 sel_we;
   logic [ADDR_SIZE-1:0] sel_addr;
   logic [7:0]           sel_wdata;

   // Round-robin: a lone requester wins; on a tie the one not served last wins
   always_comb begin
      grant0    = req0_valid & (~req1_valid | last_q);
      grant1    = req1_valid & (~req0_valid | ~last_q);
      sel_we    = grant1 ? req1_we : req0_we;
      sel_addr  = grant1 ? req1_addr : req0_addr;
      sel_wdata = grant1 ? req1_wdata : req0_wdata;
   end

   assign req0_ready   = (state_q == IDLE) & grant0;
   assign req1_ready   = (state_q == IDLE) & grant1;
   assign ram_din      = din_q;
   assign ram_rx_valid = rxv_q;
   assign rsp0_valid   = rspv_q[0];
   assign rsp1_valid   = rspv_q[1];
   assign rsp0_err     = err_q[0];
   assign rsp1_err     = err_q[1];
   assign rsp0_rdata   = rdata0_q;
   assign rsp1_rdata   = rdata1_q;

   // Next-state, RAM command and single-cycle response generation
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      din_d    = '0;
      rxv_d    = 1'b0;
      rspv_d   = '0;
      err_d    = '0;
      rdata0_d = '0;
      rdata1_d = '0;
      unique case (state_q)
         IDLE: begin
            if (grant0 | grant1) begin
               id_d    = grant1;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               last_d  = grant1;
               din_d   = {sel_we ? 2'b00 : 2'b10, 8'(sel_addr)};
               rxv_d   = 1'b1;
               state_d = ADDR;
            end
         end
         ADDR: begin
            din_d   = {we_q ? 2'b01 : 2'b11, we_q ? wdata_q : 8'h00};
            rxv_d   = 1'b1;
            state_d = DATA;
         end
         DATA: begin
            if (we_q) begin
               rspv_d[id_q] = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d   = '0;
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (ram_tx_valid) begin
               rspv_d[id_q] = 1'b1;
               if (id_q) rdata1_d = ram_dout;
               else      rdata0_d = ram_dout;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rspv_d[id_q] = 1'b1;
               err_d[id_q]  = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q  <= IDLE;
         id_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         last_q   <= 1'b1;
         cnt_q    <= '0;
         din_q    <= '0;
         rxv_q    <= 1'b0;
         rspv_q   <= '0;
         err_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         din_q    <= din_d;
         rxv_q    <= rxv_d;
         rspv_q   <= rspv_d;
         err_q    <= err_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Two-requester controller that shares one single-port SPI RAM. It turns each atomic read or write transaction into the RAM's two-step din[9:8] command sequence (address hold, then data or read) and returns read data or a write acknowledge to the requester that issued it. Arbitration is round-robin, and the two command steps are never interleaved, because the RAM holds a single shared internal address.

Parameters:
ADDR_SIZE, 8, RAM address width; equals the RAM's ADD_SIZE.
TIMEOUT, 4, max WAIT_RD cycles without ram_tx_valid before an error response; must be >=1.

Ports:
clk  input  1  clock; all logic on rising edge.
arst_n  input  1  synchronous active-low reset (sampled on the clk rising edge only, despite the name).
req0_valid  input  1  requester 0 transaction request; held with its fields until req0_ready.
req0_ready  output  1  requester 0 accepted this cycle; combinational.
req0_we  input  1  1=write, 0=read.
req0_addr  input  ADDR_SIZE  transaction address.
req0_wdata  input  8  write data; ignored for reads.
rsp0_valid  output  1  one-cycle response pulse to requester 0.
rsp0_rdata  output  8  read data; 0 for writes and errors.
rsp0_err  output  1  read timeout, qualified by rsp0_valid.
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err  same as requester 0.
ram_din  output  10  to RAM din; registered.
ram_rx_valid  output  1  to RAM rx_valid; registered.
ram_dout  input  8  from RAM dout.
ram_tx_valid  input  1  from RAM tx_valid.

Behaviour:
- Reset (arst_n=0 at edge):
  - state=IDLE; ram_din=0, ram_rx_valid=0.
  - All rsp*_valid/rdata/err=0; timeout counter=0.
  - last_grant=1, so req0 wins the first tie.
- Reset mid-transaction: abandon it, no response; the RAM internal address is left stale.
- States: IDLE, ADDR, DATA, WAIT_RD.
- IDLE arbitration (combinational):
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = (state==IDLE) & grantN; at most one ready high.
  - Ready is never high outside IDLE.
- Accept edge (IDLE, ready high):
  - Latch id, we, addr, wdata; last_grant<=id.
  - ram_din<={we?2'b00:2'b10, addr}; ram_rx_valid<=1; state<=ADDR.
- ADDR (RAM samples the address step):
  - Next edge: ram_din<={we?2'b01:2'b11, we?wdata:8'h00}; ram_rx_valid<=1; state<=DATA.
- DATA (RAM samples the data/read step):
  - Next edge: ram_rx_valid<=0 and ram_din<=0.
  - Write: rspN_valid<=1, rdata=0, err=0; state<=IDLE.
  - Read: state<=WAIT_RD; counter<=0.
- WAIT_RD:
  - ram_tx_valid=1: rspN_valid<=1, rspN_rdata<=ram_dout, err=0; state<=IDLE.
  - Otherwise counter++. When counter reaches TIMEOUT-1 with no tx_valid: rspN_valid<=1, rdata=0, err=1; state<=IDLE.
- Response signals:
  - rsp*_valid is a single-cycle pulse; rdata/err return to 0 the cycle after.
  - Only the latched requester's rsp pulses.
- Latency, counted in cycles after the accept edge:
  - Write: ram_rx_valid high for cycles 1-2; rsp pulse in cycle 3.
  - Read: tx_valid seen in cycle 3 with a nominal RAM; rsp pulse in cycle 4.
- Back-to-back: the response-pulse cycle is IDLE, so a new request can be accepted in that same cycle.
  - Maximum throughput: 1 write per 3 cycles, 1 read per 4 cycles.
- ram_tx_valid outside WAIT_RD is ignored.
- Request inputs are sampled only on the accept edge; changes after acceptance have no effect.

Test Plan:
1. Write then read: req0 write addr 8'h3C data 8'hA5, then req0 read 8'h3C.
   -> RAM sees din 10'h03C, then 10'h1A5; rsp0_valid in cycle 3 with rdata=0.
   -> Read: RAM sees 10'h23C, then 10'h300; rsp0_valid in cycle 4 with rdata=8'hA5, err=0.
2. Simultaneous requests out of reset: req0 and req1 both issue writes, held continuously.
   -> Grants go 0,1,0,1 in that order; each ready is a single cycle.
   -> The RAM never sees two consecutive address steps.
3. Read timeout: force ram_tx_valid=0 on a req1 read of 8'h10, TIMEOUT=4.
   -> rsp1_valid with err=1 and rdata=0 exactly 4 WAIT_RD cycles after entering the state.
   -> The next request is accepted in that same cycle.
4. Reset during DATA of a req0 read: arst_n=0 for one edge.
   -> No rsp0_valid; ram_rx_valid=0 and state IDLE the next cycle.
   -> A subsequent req1 read returns correct data.
5. Back-to-back: req1 writes addr 8'hFF data 8'h5A, then addr 8'h00 data 8'hC3, issued on the rsp cycle.
   -> Accepts are 3 cycles apart.
   -> Read-back of 8'hFF returns 8'h5A and of 8'h00 returns 8'hC3, confirming address wrap extremes.
6. Spurious tx_valid: drive ram_tx_valid=1 while in IDLE.
   -> No rsp*_valid.
